// File: rtl/mcycle_pkg.sv
// Shared constants and state encoding for the RV32M iterative multiply/divide unit.
package mcycle_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MCYCLE_ITER = 32;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mcycle_state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/mcycle_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module mcycle_div_step (
    input  logic [32:0] rem,
    input  logic [31:0] divisor,
    input  logic        dividend_bit,
    output logic [32:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted  = {rem[31:0], dividend_bit};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        // No borrow means the shifted remainder is at least the divisor.
        q_bit    = ~diff[33];
        rem_next = q_bit ? diff[32:0] : shifted;
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative RV32M execute unit: 32-cycle shift-add multiply and restoring divide.
// Handshake: Start is accepted in any state except COMPUTE; Done pulses for one cycle with Result valid.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output mcycle_state_t    dbg_state
);

    localparam logic [5:0] LAST_ITER = 6'(MCYCLE_ITER - 1);

    mcycle_state_t state, state_next;

    logic [5:0]  cnt;
    logic [2:0]  f3_q;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_res;
    logic        neg_rem;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [32:0] rem;

    logic        accept;
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] mag_a_c, mag_b_c;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_result;

    logic [32:0] hi_sum;
    logic [63:0] prod_nxt;
    logic [32:0] rem_nxt;
    logic        q_bit;
    logic [31:0] quo_nxt;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] final_result;

    assign accept    = Start & (state != ST_COMPUTE);
    assign Busy      = (state == ST_COMPUTE) | (Start & (state != ST_COMPUTE));
    assign Done      = (state == ST_DONE);
    assign dbg_state = state;

    // Operand conditioning at acceptance: magnitudes plus result-sign flags.
    always_comb begin
        a_signed = (Funct3 == F3_MULH) | (Funct3 == F3_MULHSU) |
                   (Funct3 == F3_DIV)  | (Funct3 == F3_REM);
        b_signed = (Funct3 == F3_MULH) | (Funct3 == F3_DIV) | (Funct3 == F3_REM);
        a_neg    = a_signed & Operand1[31];
        b_neg    = b_signed & Operand2[31];
        mag_a_c  = a_neg ? neg32(Operand1) : Operand1;
        mag_b_c  = b_neg ? neg32(Operand2) : Operand2;

        div_zero = Funct3[2] & (Operand2 == 32'd0);
        div_ovf  = Funct3[2] & ~Funct3[0] & (Operand1 == INT_MIN) & (Operand2 == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;

        special_result = 32'd0;
        if (div_zero)
            special_result = Funct3[1] ? Operand1 : DIV_BY_ZERO_Q;
        else if (div_ovf)
            special_result = Funct3[1] ? 32'd0 : INT_MIN;
    end

    // Multiply: add multiplicand into the high half when the multiplier LSB is set, then shift right.
    always_comb begin
        hi_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
        prod_nxt = {hi_sum, prod[31:1]};
    end

    mcycle_div_step u_div_step (
        .rem          (rem),
        .divisor      (mag_b),
        .dividend_bit (quo[31]),
        .rem_next     (rem_nxt),
        .q_bit        (q_bit)
    );

    assign quo_nxt = {quo[30:0], q_bit};

    // Sign fix and result selection on the final iteration's values.
    always_comb begin
        prod_fix = neg_res ? (~prod_nxt + 64'd1) : prod_nxt;
        quo_fix  = neg_res ? neg32(quo_nxt) : quo_nxt;
        rem_fix  = neg_rem ? neg32(rem_nxt[31:0]) : rem_nxt[31:0];
        case (f3_q)
            F3_MUL:                        final_result = prod_fix[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_result = prod_fix[63:32];
            F3_DIV, F3_DIVU:               final_result = quo_fix;
            default:                       final_result = rem_fix;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (Start)
                    state_next = special ? ST_DONE : ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (cnt == LAST_ITER)
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt     <= 6'd0;
            f3_q    <= 3'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            prod    <= 64'd0;
            quo     <= 32'd0;
            rem     <= 33'd0;
            Result  <= '0;
        end else if (accept) begin
            cnt     <= 6'd0;
            f3_q    <= Funct3;
            mag_a   <= mag_a_c;
            mag_b   <= mag_b_c;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            prod    <= {32'd0, mag_b_c};
            quo     <= mag_a_c;
            rem     <= 33'd0;
            if (special)
                Result <= special_result;
        end else if (state == ST_COMPUTE) begin
            cnt <= cnt + 6'd1;
            if (f3_q[2]) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
            end else begin
                prod <= prod_nxt;
            end
            if (cnt == LAST_ITER)
                Result <= final_result;
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed and random checks of mcycle_unit against a reference model and a result queue.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] Operand1 = 32'd0;
    logic [31:0] Operand2 = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .Start     (Start),
        .Funct3    (Funct3),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives Start for cycle 0 and returns just after edge 0 (cycle 1).
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input bit push);
        @(posedge CLK);
        #1;
        Start    = 1'b1;
        Funct3   = f3;
        Operand1 = a;
        Operand2 = b;
        if (push) exp_q.push_back(exp);
        @(negedge CLK);
        check("busy_cycle0", {31'd0, Busy}, 32'd1);
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int lat, input string tag);
        int cyc;
        bit found;
        logic [31:0] exp;
        cyc = 1;
        found = 1'b0;
        while (!found && cyc <= 40) begin
            @(negedge CLK);
            if (Done === 1'b1) begin
                found = 1'b1;
            end else begin
                check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
                @(posedge CLK);
                cyc++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, found}, 32'd1);
        if (found) begin
            check({tag, "_latency"}, cyc, lat);
            check({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
            check({tag, "_queue"}, exp_q.size(), 32'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check({tag, "_result"}, Result, exp);
                @(negedge CLK);
                check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
                check({tag, "_result_hold"}, Result, exp);
            end
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          done_seen;
        logic [31:0] exp;

        // Reset state; Busy follows Start combinationally.
        Start = 1'b1;
        @(negedge CLK);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst_result", Result, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_busy_eq_start", {31'd0, Busy}, 32'd1);
        Start = 1'b0;
        #1;
        check("rst_busy_low", {31'd0, Busy}, 32'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;

        start_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        wait_done(33, "mul");
        start_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        wait_done(33, "mulhu");
        start_op(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done(33, "mulh");
        start_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(33, "mulhsu");
        start_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        wait_done(33, "div");
        start_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
        wait_done(33, "rem");
        start_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done(33, "divu");
        start_op(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
        wait_done(33, "remu");
        start_op(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done(1, "divu_zero");
        start_op(F3_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_done(1, "remu_zero");
        start_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(1, "div_ovf");
        start_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_done(1, "rem_ovf");

        // Back-to-back: second Start lands in the first op's DONE cycle.
        @(posedge CLK);
        #1;
        Start = 1'b1; Funct3 = F3_MUL; Operand1 = 32'd3; Operand2 = 32'd4;
        exp_q.push_back(32'd12);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (32) @(posedge CLK);
        #1;
        Start = 1'b1; Funct3 = F3_DIV; Operand1 = 32'd12; Operand2 = 32'd5;
        exp_q.push_back(32'd2);
        @(negedge CLK);
        check("b2b_done1", {31'd0, Done}, 32'd1);
        check("b2b_busy_reassert", {31'd0, Busy}, 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("b2b_result1", Result, exp);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        wait_done(33, "b2b_div");

        // Reset during cycle 10 of a MUL aborts it without a Done.
        start_op(F3_MUL, 32'd5, 32'd6, 32'd0, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        RESETn = 1'b0;
        #2;
        check("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("abort_result", Result, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_result_idle", Result, 32'd0);
        start_op(F3_MUL, 32'd2, 32'd2, 32'd4, 1'b1);
        wait_done(33, "mul_after_abort");

        // Random operations checked against the reference model.
        for (int i = 0; i < 10; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            start_op(rf3, ra, rb, ref_model(rf3, ra, rb), 1'b1);
            wait_done(ref_latency(rf3, ra, rb), "rand");
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Iterative multi-cycle execute unit for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), sitting in the Execute stage beside the ALU. It is the producer side of the pipeline's stall interface. Its `Busy` output feeds the hazard unit, which holds F/D/E and bubbles M while an M-extension operation is in flight. The result is muxed into `ALUResultE` in the cycle `Busy` falls.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `CLK`  in  1  rising-edge clock.
- `RESETn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  E-stage instruction is an M-extension op; sampled in IDLE or DONE.
- `Funct3`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Operand1`  in  32  rs1 value (post-forwarding).
- `Operand2`  in  32  rs2 value (post-forwarding).
- `Busy`  out  1  stall request to the hazard unit.
- `Done`  out  1  one-cycle pulse: `Result` is valid this cycle.
- `Result`  out  32  selected result; held until the next accepted Start.

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE or DONE with `Start=1`: latch `Funct3` and operands, and latch operand magnitudes plus result-sign flags according to the signedness of the op.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both operands signed.
  - MUL/MULHU/DIVU/REMU: unsigned magnitudes; MUL low word is sign-agnostic.
  - Clear the 6-bit iteration counter.
  - Next state is COMPUTE, or DONE for the special cases below.
- Special divide cases bypass COMPUTE and go straight to DONE:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- COMPUTE, multiply: shift-add on a 64-bit product register; one multiplier bit per cycle, LSB first.
- COMPUTE, divide: restoring division, one quotient bit per cycle, MSB first, on a 33-bit partial remainder.
- COMPUTE ends when the counter reaches 31, i.e. after 32 iterations, then goes to DONE.
- On entry to DONE, apply the sign fix:
  - Product: two's-complement negate the 64-bit value if the signs differ.
  - Quotient: negate if the signs differ.
  - Remainder: takes the dividend sign.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: `Done=1`. Next state is IDLE, or COMPUTE/DONE if `Start=1`, which allows back-to-back M ops.
- `Busy` is combinational: `(state==COMPUTE) | (Start & state!=COMPUTE)`.
  - It is 0 in the DONE cycle unless a new Start arrives. A new Start in DONE comes only from the next instruction, after the pipeline advances.
- `Start` is ignored in COMPUTE. Operands are not resampled mid-operation; the hazard unit keeps E frozen anyway.

## Timing
- Reset (async, RESETn=0): state=IDLE, counter=0, Result=0, Done=0.
  - Busy then equals `Start`, because Busy is combinational.
  - Reset mid-COMPUTE aborts the operation; no Done is produced.
- Normal op: Start sampled at edge 0 (Busy=1 combinationally in cycle 0), COMPUTE for cycles 1..32, DONE in cycle 33.
  - Busy is high for 33 cycles; Done and Result are valid in cycle 33.
- Special divide: Start at edge 0, DONE in cycle 1; Busy is high only in cycle 0.
- `Result` is registered. It changes only on entry to DONE and is stable from DONE until the next DONE.
- No combinational path from the operands to `Result`.

## Structure
- Shared package `mcycle_pkg`:
  - Funct3 localparams.
  - State encoding (2-bit IDLE/COMPUTE/DONE).
  - `MCYCLE_ITER = 32`.
  - Special-case constants: DIV_BY_ZERO_Q = 0xFFFFFFFF, INT_MIN = 0x80000000.
- Natural sub-module `mcycle_div_step`: one combinational restoring step. Inputs are the partial remainder, divisor and next dividend bit; outputs are the new remainder and quotient bit. It is unit-testable in isolation.
- The multiply step stays inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) → Result 0xFFFFFFEB in cycle 33. Busy high in cycles 0-32, Done a single pulse.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both with Done in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1.
- Back-to-back: Start MUL 3×4, then Start DIV 12/5 held in the DONE cycle → Result 12 at DONE, Busy re-asserts that same cycle, Result 2 at the second DONE (cycle 66).
- Reset pulse in cycle 10 of a MUL → state IDLE, Result 0, no Done. A following MUL 2×2 → 4 at its cycle 33.
